// File: rtl/sram_arbiter.sv
// Arbiter sharing one single-port SRAM bus between instruction fetch and load/store.
// Optional ARB_TIMEOUT_EN: force completion (read data 0, timeout_o pulse) after TIMEOUT_CYC bus-wait cycles.
module sram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_i,
    input  logic                if_ce_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_ready_o,
    input  logic                d_ce_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ready_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {IDLE, D_BUSY, IF_BUSY} state_t;

    state_t state;
    logic   if_done, d_done;
    logic   advance;
    logic   expire;
    logic   done_now;

    assign stallreq_o = (if_ce_i & ~if_done) | (d_ce_i & ~d_done);
    assign advance    = ~stallreq_o & ~hold_i;
    assign if_ready_o = if_done;
    assign d_ready_o  = d_done;
    assign done_now   = bus_ack_i | expire;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    assign expire = (state != IDLE) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Every BUSY period is entered from IDLE, so holding the count at 0 there restarts it per access.
    always_ff @(posedge clk) begin
        if (!rst || state == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            timeout_o <= 1'b0;
        else
            timeout_o <= expire & ~bus_ack_i;
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            if_data_o   <= '0;
            d_rdata_o   <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            // Clear first so a completion on the same edge still leaves its flag set.
            if (advance) begin
                if_done <= 1'b0;
                d_done  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (d_ce_i && !d_done) begin
                        state       <= D_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= d_we_i;
                        bus_sel_o   <= d_sel_i;
                        bus_addr_o  <= d_addr_i;
                        bus_wdata_o <= d_wdata_i;
                    end else if (if_ce_i && !if_done) begin
                        state       <= IF_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= '1;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                D_BUSY, IF_BUSY: begin
                    if (done_now) begin
                        state       <= IDLE;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= '0;
                        bus_addr_o  <= '0;
                        bus_wdata_o <= '0;
                        if (state == D_BUSY) begin
                            d_done <= 1'b1;
                            if (!bus_we_o)
                                d_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
                        end else begin
                            if_done   <= 1'b1;
                            if_data_o <= bus_ack_i ? bus_rdata_i : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected bus cycles and read data, a monitor pops on DUT events.
module tb_sram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0, rst = 1'b0, hold_i = 1'b0;
    logic          if_ce_i = 1'b0, d_ce_i = 1'b0, d_we_i = 1'b0, bus_ack_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0, d_addr_i = '0;
    logic [SW-1:0] d_sel_i = '0;
    logic [DW-1:0] d_wdata_i = '0, bus_rdata_i = '0;
    logic [DW-1:0] if_data_o, d_rdata_o, bus_wdata_o;
    logic [AW-1:0] bus_addr_o;
    logic [SW-1:0] bus_sel_o;
    logic          if_ready_o, d_ready_o, bus_req_o, bus_we_o, stallreq_o, timeout_o;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdata;
    } bus_txn_t;

    bus_txn_t      exp_bus[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_d[$];
    int            checks = 0, errors = 0;
    int            wait_states = 0;
    bit            resp_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [AW-1:0] a, input logic we, input logic [SW-1:0] sel,
                            input logic [DW-1:0] wd);
        bus_txn_t t;
        t.addr = a; t.we = we; t.sel = sel; t.wdata = wd;
        exp_bus.push_back(t);
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        case (a)
            32'h0000_0100: return 32'h3C01_0101;
            32'h0000_0104: return 32'h2402_0005;
            32'h0000_2000: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks after wait_states bus cycles, driven on the falling edge.
    initial begin
        int ws;
        ws = 0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                bus_ack_i = 1'b0;
                if (bus_req_o === 1'b1) begin
                    if (ws == wait_states) begin
                        bus_ack_i   = 1'b1;
                        bus_rdata_i = mem_rd(bus_addr_o);
                        ws = 0;
                    end else begin
                        ws++;
                    end
                end else begin
                    ws = 0;
                end
            end else begin
                ws = 0;
            end
        end
    end

    // Monitor: compare each new bus cycle and each ready rise against the scoreboard.
    initial begin
        logic     bq, iq, dq;
        bus_txn_t e;
        bq = 1'b0; iq = 1'b0; dq = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req_o === 1'b1 && !bq) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_txn: unexpected bus cycle at addr 0x%0h", bus_addr_o);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_addr", bus_addr_o, e.addr);
                    chk("bus_we", bus_we_o, e.we);
                    chk("bus_sel", bus_sel_o, e.sel);
                    chk("bus_wdata", bus_wdata_o, e.wdata);
                end
            end
            if (if_ready_o === 1'b1 && !iq) begin
                if (exp_if.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_ready: unexpected completion, data 0x%0h", if_data_o);
                end else chk("if_data", if_data_o, exp_if.pop_front());
            end
            if (d_ready_o === 1'b1 && !dq) begin
                if (exp_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_ready: unexpected completion, data 0x%0h", d_rdata_o);
                end else chk("d_rdata", d_rdata_o, exp_d.pop_front());
            end
            bq = (bus_req_o === 1'b1);
            iq = (if_ready_o === 1'b1);
            dq = (d_ready_o === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_st, dc, ic, nreq, nrdy, n;
        repeat (3) step();
        @(negedge clk);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_d_ready", d_ready_o, 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_stall", stallreq_o, 0);
        chk("rst_timeout", timeout_o, 0);
        step(); rst = 1'b1;

        // Fetch only, zero wait states.
        step();
        if_ce_i = 1'b1; if_addr_i = 32'h100; wait_states = 0;
        push_bus(32'h100, 1'b0, 4'hF, 32'h0);
        exp_if.push_back(32'h3C01_0101);
        @(negedge clk);
        chk("t1_c0_bus_req", bus_req_o, 0);
        chk("t1_c0_stall", stallreq_o, 1);
        @(negedge clk);
        chk("t1_c1_bus_req", bus_req_o, 1);
        chk("t1_c1_if_ready", if_ready_o, 0);
        @(negedge clk);
        chk("t1_c2_if_ready", if_ready_o, 1);
        chk("t1_c2_stall", stallreq_o, 0);
        chk("t1_c2_bus_req", bus_req_o, 0);
        step(); if_ce_i = 1'b0;
        @(negedge clk);
        chk("t1_clear", if_ready_o, 0);

        // Simultaneous load and fetch, two wait states each.
        step();
        if_ce_i = 1'b1; if_addr_i = 32'h104;
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h2000; d_wdata_i = '0;
        wait_states = 2;
        push_bus(32'h2000, 1'b0, 4'hF, 32'h0);
        push_bus(32'h104, 1'b0, 4'hF, 32'h0);
        exp_d.push_back(32'h1234_5678);
        exp_if.push_back(32'h2402_0005);
        n_st = 0; dc = -1; ic = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stallreq_o) n_st++;
            if (d_ready_o && dc < 0) dc = i;
            if (if_ready_o && ic < 0) ic = i;
            if (!stallreq_o) break;
        end
        chk("t2_stall_cycles", n_st, 8);
        chk("t2_d_ready_cycle", dc, 4);
        chk("t2_if_ready_cycle", ic, 8);
        step(); if_ce_i = 1'b0; d_ce_i = 1'b0;

        // Store: bus carries the latched store fields, load data untouched.
        step();
        d_ce_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011; d_addr_i = 32'h2004; d_wdata_i = 32'hDEAD_BEEF;
        wait_states = 1;
        push_bus(32'h2004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        exp_d.push_back(32'h1234_5678);
        n = 0;
        @(negedge clk);
        while (stallreq_o && n < 10) begin @(negedge clk); n++; end
        chk("t3_done", stallreq_o, 0);
        step(); d_ce_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0;

        // Fetch completes under a 5-cycle non-memory hold.
        step();
        hold_i = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h108; d_sel_i = 4'hF; wait_states = 0;
        push_bus(32'h108, 1'b0, 4'hF, 32'h0);
        exp_if.push_back(mem_rd(32'h108));
        nreq = 0; nrdy = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            nreq += int'(bus_req_o);
            nrdy += int'(if_ready_o);
        end
        step(); hold_i = 1'b0;
        @(negedge clk);
        nreq += int'(bus_req_o);
        chk("t4_ready_hold_fall", if_ready_o, 1);
        step(); if_ce_i = 1'b0;
        @(negedge clk);
        nreq += int'(bus_req_o);
        chk("t4_cleared", if_ready_o, 0);
        chk("t4_bus_cycles", nreq, 1);
        chk("t4_ready_cycles", nrdy, 5);

        // Load whose ce drops mid-transaction still completes.
        step();
        d_ce_i = 1'b1; d_addr_i = 32'h2008; wait_states = 2;
        push_bus(32'h2008, 1'b0, 4'hF, 32'h0);
        exp_d.push_back(mem_rd(32'h2008));
        step(); d_ce_i = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("t5_ready", d_ready_o, 1);
        chk("t5_stall", stallreq_o, 0);
        @(negedge clk);
        chk("t5_cleared", d_ready_o, 0);

        // Reset during D_BUSY, ack arriving the cycle after.
        step();
        resp_en = 1'b0; bus_ack_i = 1'b0;
        d_ce_i = 1'b1; d_addr_i = 32'h3000;
        push_bus(32'h3000, 1'b0, 4'hF, 32'h0);
        step(); rst = 1'b0; d_ce_i = 1'b0;
        @(negedge clk);
        chk("t6_busy", bus_req_o, 1);
        step(); rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t6_bus_req", bus_req_o, 0);
        chk("t6_d_ready", d_ready_o, 0);
        chk("t6_d_rdata", d_rdata_o, 0);
        chk("t6_if_data", if_data_o, 0);
        chk("t6_bus_addr", bus_addr_o, 0);
        step(); bus_ack_i = 1'b0;
        @(negedge clk);
        chk("t6_late_ack_ready", d_ready_o, 0);
        chk("t6_late_ack_req", bus_req_o, 0);
        resp_en = 1'b1;

`ifdef ARB_TIMEOUT_EN
        // No ack: forced completion after 4 bus cycles.
        step();
        resp_en = 1'b0;
        d_ce_i = 1'b1; d_addr_i = 32'h4000;
        push_bus(32'h4000, 1'b0, 4'hF, 32'h0);
        exp_d.push_back(32'h0);
        nreq = 0; n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nreq += int'(bus_req_o);
            n += int'(timeout_o);
            if (i == 5) begin
                chk("t7_timeout", timeout_o, 1);
                chk("t7_d_ready", d_ready_o, 1);
            end
        end
        step(); d_ce_i = 1'b0; resp_en = 1'b1;
        chk("t7_bus_cycles", nreq, 4);
        chk("t7_pulses", n, 1);
`endif

        repeat (3) step();
        chk("sb_drain", exp_bus.size() + exp_if.size() + exp_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one unified single-port SRAM bus between instruction fetch (IF requester) and load/store (data requester, MEM stage).
- Multi-cycle FSM with variable-latency ack handshake.
- Holds per-requester completion flags and raises a stall request to the pipeline controller until every active requester has its data.
- Sits between pc_reg/if_id/mem and the external memory; its stallreq_o feeds the controller alongside the ID and EX stall requests.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- TIMEOUT_CYC, 255, bus-wait cycles before forced completion (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- hold_i  in  1  controller is holding the pipeline for a non-memory reason.
- if_ce_i  in  1  fetch request, held level until the pipeline advances.
- if_addr_i  in  ADDR_W  fetch address, stable while if_ce_i=1.
- if_data_o  out  DATA_W  fetched word.
- if_ready_o  out  1  fetch complete, data valid (level).
- d_ce_i  in  1  data request.
- d_we_i  in  1  1=store, 0=load.
- d_sel_i  in  DATA_W/8  byte enables.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data.
- d_ready_o  out  1  data access complete (level).
- bus_req_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write.
- bus_sel_o  out  DATA_W/8  bus byte enables.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data, valid with ack.
- bus_ack_i  in  1  bus completion, single cycle.
- stallreq_o  out  1  stall request to controller.
- timeout_o  out  1  one-cycle pulse on forced completion.

Behaviour:
- Reset: state IDLE; all outputs 0; both done flags 0; data registers 0.
- FSM states: IDLE, D_BUSY, IF_BUSY.
- IDLE:
  - If d_ce_i and !d_done: latch d_addr/we/sel/wdata and go to D_BUSY.
  - Else if if_ce_i and !if_done: latch if_addr (we=0, sel=all ones) and go to IF_BUSY.
  - Data has fixed priority over fetch because it belongs to the older instruction.
- BUSY states:
  - bus_req_o=1; bus_* driven only from the latched copy, never from live inputs.
  - Bus outputs are 0 in IDLE.
  - On bus_ack_i=1: capture bus_rdata_i into d_rdata_o or if_data_o (stores leave d_rdata_o unchanged), set the matching done flag, return to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; bus_req_o=1 in cycle 1.
  - Ack in cycle 1 gives ready=1 in cycle 2. Minimum 2 cycles, plus 1 cycle per bus wait state.
- Outputs from state:
  - if_ready_o=if_done; d_ready_o=d_done.
  - stallreq_o is combinational: (if_ce_i & !if_done) | (d_ce_i & !d_done).
- Done-flag clear: both done flags clear at an edge where stallreq_o=0 and hold_i=0 (the pipeline advances). Data outputs hold their value until overwritten.
- Flags stay set while hold_i=1. No repeated bus access for a completed requester during non-memory stalls.
- Both requesting in the same cycle: data serviced first, then fetch; stallreq_o stays 1 until both are done.
- bus_ack_i in IDLE is ignored.
- A requester dropping ce mid-transaction does not abort the bus cycle; the result is captured and its flag is cleared at the next advance edge.
- Reset mid-transaction: IDLE next cycle, bus_req_o=0, and a late ack is ignored.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - 8-bit-minimum counter runs in BUSY states.
  - After TIMEOUT_CYC cycles without ack: complete with read data 0 and set the done flag.
  - timeout_o pulses 1 cycle; return to IDLE; counter resets on every BUSY entry.
- Not defined: the FSM waits indefinitely; timeout_o is tied 0.

Test Plan:
- Fetch only, if_addr=0x100, ack in 1st bus cycle with rdata=0x3C010101 -> bus_req 1 cycle, if_ready=1 and if_data=0x3C010101 two cycles after request, stallreq drops the same cycle.
- Fetch 0x104 plus load 0x2000 simultaneously, 2 wait states each -> bus_addr 0x2000 first, then 0x104; stallreq=1 for 8 cycles; d_ready before if_ready.
- Store addr 0x2004, sel=4'b0011, wdata=0xDEADBEEF -> bus_we=1, bus_sel=0011, bus_wdata=0xDEADBEEF; d_rdata_o unchanged.
- Fetch completes while hold_i=1 for 5 cycles -> exactly one bus_req cycle; if_ready held for 5 cycles; flag clears at the edge hold_i falls.
- rst=0 asserted during D_BUSY, ack arrives the cycle after -> all outputs 0, no ready, FSM in IDLE.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=4, no ack -> timeout_o pulse after 4 bus cycles, d_ready=1, d_rdata=0.
